// File: rtl/panel_pkg.sv
// Shared 7-segment definitions for the panel drivers and the scan receiver.
// Segment codes are stored with the decimal point clear; bit 7 is segment a.
package panel_pkg;

  typedef logic [7:0] seg_t;

  localparam int unsigned SEG_DP = 0;

  localparam seg_t SEG_0 = 8'hFC;
  localparam seg_t SEG_1 = 8'h60;
  localparam seg_t SEG_2 = 8'hDA;
  localparam seg_t SEG_3 = 8'hF2;
  localparam seg_t SEG_4 = 8'h66;
  localparam seg_t SEG_5 = 8'hB6;
  localparam seg_t SEG_6 = 8'hBE;
  localparam seg_t SEG_7 = 8'hE0;
  localparam seg_t SEG_8 = 8'hFE;
  localparam seg_t SEG_9 = 8'hE6;
  localparam seg_t SEG_A = 8'hEE;
  localparam seg_t SEG_B = 8'h3E;
  localparam seg_t SEG_C = 8'h1A;
  localparam seg_t SEG_D = 8'h7A;
  localparam seg_t SEG_E = 8'h9E;
  localparam seg_t SEG_F = 8'h8E;

endpackage

// File: rtl/panelseg_decode.sv
// Combinational 7-segment to hex decoder; hit_o is low for any pattern that
// is not one of the sixteen hex glyphs (blank included).
module panelseg_decode
  import panel_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    hit_o    = 1'b1;
    nibble_o = 4'h0;
    case (seg_i)
      SEG_0[7:1]: nibble_o = 4'h0;
      SEG_1[7:1]: nibble_o = 4'h1;
      SEG_2[7:1]: nibble_o = 4'h2;
      SEG_3[7:1]: nibble_o = 4'h3;
      SEG_4[7:1]: nibble_o = 4'h4;
      SEG_5[7:1]: nibble_o = 4'h5;
      SEG_6[7:1]: nibble_o = 4'h6;
      SEG_7[7:1]: nibble_o = 4'h7;
      SEG_8[7:1]: nibble_o = 4'h8;
      SEG_9[7:1]: nibble_o = 4'h9;
      SEG_A[7:1]: nibble_o = 4'hA;
      SEG_B[7:1]: nibble_o = 4'hB;
      SEG_C[7:1]: nibble_o = 4'hC;
      SEG_D[7:1]: nibble_o = 4'hD;
      SEG_E[7:1]: nibble_o = 4'hE;
      SEG_F[7:1]: nibble_o = 4'hF;
      default:    hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/panelscan_rx.sv
// Multiplexed 7-segment bus receiver: stability filter, per-digit capture and
// frame-complete pulse. Define PANELSCAN_SYNC_EN for a 2-flop input synchronizer.
module panelscan_rx
  import panel_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            seg_i,
  input  logic [DIGITS-1:0]     dig_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  frame_o
);

  localparam int unsigned SW = DIGITS + 8;
  localparam logic [7:0] StableCnt = 8'(STABLE);

  logic [SW-1:0] raw;
  logic [SW-1:0] samp;

  assign raw = {seg_i, dig_i};

`ifdef PANELSCAN_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = raw;
`endif

  seg_t              seg;
  logic [DIGITS-1:0] dig;

  assign seg = samp[SW-1 -: 8];
  assign dig = samp[DIGITS-1:0];

  logic [SW-1:0]       prev_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q, err_q, seen_q, seen_upd;
  logic                frame_q;
  logic                same, onehot, capture;
  logic                hit;
  logic [3:0]          nibble;

  panelseg_decode u_decode (
    .seg_i    (seg[7:1]),
    .hit_o    (hit),
    .nibble_o (nibble)
  );

  always_comb begin
    same = (samp == prev_q);
    if (!same) begin
      cnt_d = 8'd1;
    end else if (cnt_q == StableCnt) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    onehot   = (dig != '0) && ((dig & (dig - DIGITS'(1))) == '0);
    // Only the step into StableCnt captures, so a held digit captures once.
    capture  = onehot && same && (cnt_q == StableCnt - 8'd1);
    seen_upd = seen_q | (capture ? dig : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      prev_q  <= samp;
      cnt_q   <= cnt_d;
      frame_q <= 1'b0;
      if (&seen_upd) begin
        frame_q <= 1'b1;
        seen_q  <= '0;
      end else begin
        seen_q  <= seen_upd;
      end
      for (int n = 0; n < int'(DIGITS); n++) begin
        if (capture && dig[n]) begin
          dp_q[n]  <= seg[SEG_DP];
          err_q[n] <= ~hit;
          if (hit) value_q[4*n +: 4] <= nibble;
        end
      end
    end
  end

  assign value_o = value_q;
  assign dp_o    = dp_q;
  assign err_o   = err_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_panelscan_rx.sv
// Randomized bench for panelscan_rx against a run-length reference model.
module tb_panelscan_rx;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 3;
`ifdef PANELSCAN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic [3:0]  dp, err;
  logic        frame;

  always #5 clk = ~clk;

  panelscan_rx #(
    .DIGITS (DIGITS),
    .STABLE (STABLE)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .seg_i   (seg),
    .dig_i   (dig),
    .value_o (value),
    .dp_o    (dp),
    .err_o   (err),
    .frame_o (frame)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: hex glyphs as seg[7:1], a at MSB.
  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h73, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

  logic [11:0] pipe [$];
  logic [11:0] m_prev;
  int          m_run;
  bit          m_fresh;
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_err, m_seen;
  logic        m_frame;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back('0);
    m_prev = '0; m_run = 0; m_fresh = 1'b1;
    m_value = '0; m_dp = '0; m_err = '0; m_seen = '0; m_frame = 1'b0;
  endtask

  task automatic model_edge();
    logic [11:0] cur, f;
    int k, idx;
    if (rst) begin
      model_reset();
      return;
    end
    cur = {seg, dig};
    if (LAT == 0) f = cur;
    else begin
      f = pipe.pop_back();
      pipe.push_front(cur);
    end
    if (m_fresh || f != m_prev) m_run = 1;
    else m_run++;
    m_fresh = 1'b0;
    m_prev  = f;
    m_frame = 1'b0;
    if (m_run == STABLE && $countones(f[3:0]) == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (f[i]) k = i;
      idx = lookup(f[11:5]);
      m_dp[k] = f[4];
      if (idx < 0) m_err[k] = 1'b1;
      else begin
        m_err[k] = 1'b0;
        m_value[4*k +: 4] = idx[3:0];
      end
      m_seen[k] = 1'b1;
      if (&m_seen) begin
        m_frame = 1'b1;
        m_seen  = '0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] s, input logic [3:0] d);
    rst = r; seg = s; dig = d;
    @(posedge clk);
    model_edge();
    #1;
    if (frame) n_frames++;
    check("value", 32'(value), 32'(m_value));
    check("dp",    32'(dp),    32'(m_dp));
    check("err",   32'(err),   32'(m_err));
    check("frame", 32'(frame), 32'(m_frame));
  endtask

  logic [7:0]  scan [4] = '{8'hF3, 8'hB6, 8'h1A, 8'h8F};
  logic [15:0] snap_v;
  logic [3:0]  snap_dp, snap_err;
  int          f0;

  initial begin
    model_reset();
    rst = 1'b1; seg = '0; dig = '0;
    repeat (3) step(1'b1, 8'h00, 4'h0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_flags", 32'({dp, err, frame}), 32'h0);

    // Full scan, two rounds: one frame per round.
    f0 = n_frames;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        repeat (5) step(1'b0, scan[d], 4'(1 << d));
    repeat (4) step(1'b0, 8'h00, 4'h0);
    check("scan_value",  32'(value), 32'hFC53);
    check("scan_err",    32'(err),   32'h0);
    check("scan_frames", 32'(n_frames - f0), 32'd2);

    // One digit held for a long time.
    f0 = n_frames;
    repeat (50) step(1'b0, 8'h60, 4'b0001);
    check("hold_value0", 32'(value[3:0]), 32'h1);
    check("hold_frames", 32'(n_frames - f0), 32'd0);

    // 2-cycle dwell must not update anything.
    repeat (LAT + 1) step(1'b0, 8'h00, 4'h0);
    snap_v = value; snap_dp = dp; snap_err = err;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] s;
      s = 8'($urandom);
      repeat (2) step(1'b0, s, 4'(1 << (i % 4)));
    end
    repeat (LAT + 1) step(1'b0, 8'h00, 4'h0);
    check("short_value", 32'(value), 32'(snap_v));
    check("short_flags", 32'({dp, err}), 32'({snap_dp, snap_err}));

    // Blank after a valid 7 on digit 2, then recovery.
    repeat (5) step(1'b0, 8'hE0, 4'b0100);
    repeat (5) step(1'b0, 8'h00, 4'b0100);
    check("blank_value2", 32'(value[11:8]), 32'h7);
    check("blank_err2",   32'(err[2]), 32'h1);
    repeat (5) step(1'b0, 8'hE0, 4'b0100);
    check("recover_err2", 32'(err[2]), 32'h0);

    // Multi-hot strobe never captures.
    snap_v = value; snap_dp = dp; snap_err = err;
    repeat (10) step(1'b0, 8'hFE, 4'b0011);
    check("multi_value", 32'(value), 32'(snap_v));
    check("multi_flags", 32'({dp, err}), 32'({snap_dp, snap_err}));

    // Reset in the middle of a stable run.
    repeat (2) step(1'b0, 8'h66, 4'b0010);
    step(1'b1, 8'h66, 4'b0010);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_flags", 32'({dp, err, frame}), 32'h0);
    repeat (6) step(1'b0, 8'h66, 4'b0010);
    check("midrst_recap", 32'(value[7:4]), 32'h4);

    // Random scan traffic with occasional resets.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] s;
      logic [3:0] d;
      int dwell;
      dwell = $urandom_range(1, 6);
      if ($urandom_range(0, 3) != 0) s = {codes[$urandom_range(0, 15)], 1'($urandom)};
      else s = 8'($urandom);
      if ($urandom_range(0, 4) != 0) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom);
      repeat (dwell) step(($urandom_range(0, 60) == 0), s, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
